// File: rtl/piso_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piso_ctrl_pkg
//  Brief    : Shared state encoding and sizing helpers for the PISO sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } piso_state_e;

    localparam int c_GAP_W = 4;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_ctrl_if
//  Brief    : Word-in / bit-out handshake bundle of the PISO sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface piso_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             load_sel;
    logic             word_done;

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, load_sel, word_done
    );

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, load_sel, word_done
    );
endinterface
`default_nettype wire

// File: rtl/piso_ctrl_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : piso_ctrl_datapath
//  Brief    : WIDTH-flop shift register with AND-OR load/shift select per bit.
//  Revision : 1.0  initial release
// ============================================================================
module piso_ctrl_datapath #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load_sel,
    input  wire logic             i_enable,
    input  wire logic [WIDTH-1:0] i_in_data,
    output logic      [WIDTH-1:0] o_reg
);

    logic [WIDTH-1:0] w_reg;
    logic [WIDTH-1:0] w_shift_src;

    // Shift moves toward whichever end is presented on ser_out, zero filling.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shift_src = {w_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_shift_src = {1'b0, w_reg[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_d;
        logic r_bit;

        assign w_d = (i_load_sel & i_in_data[i]) | (~i_load_sel & w_shift_src[i]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_bit <= 1'b0;
            end else if (i_enable) begin
                r_bit <= w_d;
            end
        end

        assign w_reg[i] = r_bit;
    end

    assign o_reg = w_reg;

endmodule
`default_nettype wire

// File: rtl/piso_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : piso_ctrl
//  Brief    : Load/shift sequencer for a parallel-in serial-out register.
//  Revision : 1.0  initial release
// ============================================================================
module piso_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    piso_ctrl_if.slave bus
);

    localparam int                   c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST = (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;
    localparam piso_state_e          c_AFTER_WORD = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    piso_state_e          r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic [c_GAP_W-1:0]   r_gap_cnt,   w_gap_nxt;
    logic                 r_ser_valid, w_ser_valid_nxt;
    logic                 r_ser_last,  w_ser_last_nxt;
    logic                 r_word_done, w_word_done_nxt;
    logic                 w_in_ready;
    logic                 w_load_sel;
    logic                 w_dp_en;
    logic [WIDTH-1:0]     w_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_ser_last  <= w_ser_last_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_gap_nxt       = r_gap_cnt;
        w_ser_valid_nxt = r_ser_valid;
        w_ser_last_nxt  = r_ser_last;
        w_word_done_nxt = 1'b0;
        w_in_ready      = 1'b0;
        w_load_sel      = 1'b0;
        w_dp_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                w_load_sel = bus.in_valid;
                if (bus.in_valid) begin
                    w_dp_en         = 1'b1;
                    w_state_nxt     = ST_SHIFT;
                    w_cnt_nxt       = '0;
                    w_ser_valid_nxt = 1'b1;
                    w_ser_last_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_ready) begin
                    w_dp_en = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt       = '0;
                        w_gap_nxt       = '0;
                        w_ser_valid_nxt = 1'b0;
                        w_ser_last_nxt  = 1'b0;
                        w_word_done_nxt = 1'b1;
                        w_state_nxt     = c_AFTER_WORD;
                    end else begin
                        w_cnt_nxt      = r_cnt + 1'b1;
                        w_ser_last_nxt = ((r_cnt + 1'b1) == c_CNT_LAST);
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    piso_ctrl_datapath #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .i_load_sel (w_load_sel),
        .i_enable   (w_dp_en),
        .i_in_data  (bus.in_data),
        .o_reg      (w_reg)
    );

    // The state register reads IDLE during reset, so the decoded outputs are masked by rst.
    assign bus.in_ready  = w_in_ready & ~rst;
    assign bus.load_sel  = w_load_sel & ~rst;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_last  = r_ser_last;
    assign bus.word_done = r_word_done;
    assign bus.ser_out   = (MSB_FIRST != 0) ? w_reg[WIDTH-1] : w_reg[0];

endmodule
`default_nettype wire

// File: tb/tb_piso_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_ctrl
//  Brief    : Three configurations of piso_ctrl driven in parallel against a word-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso_ctrl;

    localparam int c_W = 4;
    localparam int MSB_OF [3] = '{1, 0, 1};
    localparam int GAP_OF [3] = '{0, 0, 2};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [c_W-1:0] in_data = '0;
    logic           in_valid = 1'b0;
    logic           ser_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    piso_ctrl_if #(.WIDTH(c_W)) if_a ();
    piso_ctrl_if #(.WIDTH(c_W)) if_b ();
    piso_ctrl_if #(.WIDTH(c_W)) if_c ();

    assign if_a.in_data = in_data;  assign if_a.in_valid = in_valid;  assign if_a.ser_ready = ser_ready;
    assign if_b.in_data = in_data;  assign if_b.in_valid = in_valid;  assign if_b.ser_ready = ser_ready;
    assign if_c.in_data = in_data;  assign if_c.in_valid = in_valid;  assign if_c.ser_ready = ser_ready;

    piso_ctrl #(.WIDTH(c_W), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    piso_ctrl #(.WIDTH(c_W), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    piso_ctrl #(.WIDTH(c_W), .MSB_FIRST(1), .GAP_CYCLES(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    // Word-level model: the word in flight, how many of its bits went out, idle cycles still owed.
    bit             m_busy [3];
    logic [c_W-1:0] m_word [3];
    int             m_pos  [3];
    int             m_gap  [3];
    bit             m_done [3];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0; m_word[i] = '0; m_pos[i] = 0; m_gap[i] = 0; m_done[i] = 1'b0;
        end
    endfunction

    // Bit order: {in_ready, ser_valid, ser_out, ser_last, load_sel, word_done}
    function automatic logic [5:0] get_obs(input int i);
        case (i)
            0:       return {if_a.in_ready, if_a.ser_valid, if_a.ser_out, if_a.ser_last, if_a.load_sel, if_a.word_done};
            1:       return {if_b.in_ready, if_b.ser_valid, if_b.ser_out, if_b.ser_last, if_b.load_sel, if_b.word_done};
            default: return {if_c.in_ready, if_c.ser_valid, if_c.ser_out, if_c.ser_last, if_c.load_sel, if_c.word_done};
        endcase
    endfunction

    function automatic logic [5:0] expected(input int i);
        logic rdy, vld, sout, last, ld, done;
        rdy  = !rst && !m_busy[i] && (m_gap[i] == 0);
        vld  = !rst && m_busy[i];
        sout = 1'b0;
        if (vld) sout = (MSB_OF[i] != 0) ? m_word[i][c_W-1-m_pos[i]] : m_word[i][m_pos[i]];
        last = vld && (m_pos[i] == c_W - 1);
        ld   = rdy && in_valid;
        done = !rst && m_done[i];
        return {rdy, vld, sout, last, ld, done};
    endfunction

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock: compare all instances mid-cycle, advance the model, return 1 time unit after the edge.
    task automatic step();
        @(negedge clk);
        if (rst) model_reset();
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d {rdy,vld,out,last,ld,done}", i), 8'(get_obs(i)), 8'(expected(i)));
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                bit rdy;
                rdy = !m_busy[i] && (m_gap[i] == 0);
                m_done[i] = 1'b0;
                if (rdy && in_valid) begin
                    m_busy[i] = 1'b1; m_word[i] = in_data; m_pos[i] = 0;
                end else if (m_busy[i] && ser_ready) begin
                    m_pos[i]++;
                    if (m_pos[i] == c_W) begin
                        m_busy[i] = 1'b0; m_pos[i] = 0; m_done[i] = 1'b1; m_gap[i] = GAP_OF[i];
                    end
                end else if (!m_busy[i] && m_gap[i] > 0) begin
                    m_gap[i]--;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [c_W-1:0] word;
        logic [c_W-1:0] seq_msb;   // first transmitted bit in [3]
        logic [c_W-1:0] seq_lsb;
    } vec_t;

    vec_t vt [4];
    int   last_a, last_c, nacc_c;

    initial begin
        vt[0] = '{word: 4'b1011, seq_msb: 4'b1011, seq_lsb: 4'b1101};
        vt[1] = '{word: 4'b1100, seq_msb: 4'b1100, seq_lsb: 4'b0011};
        vt[2] = '{word: 4'b0001, seq_msb: 4'b0001, seq_lsb: 4'b1000};
        vt[3] = '{word: 4'b0110, seq_msb: 4'b0110, seq_lsb: 4'b0110};
        model_reset();

        repeat (2) step();
        rst = 1'b0;
        step();
        check("idle in_ready after reset", 8'(if_a.in_ready), 8'd1);

        // Serial order, last flag and completion for both bit orders
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1; in_data = vt[v].word; ser_ready = 1'b1;
            step();
            in_valid = 1'b0;
            for (int b = 0; b < c_W; b++) begin
                check($sformatf("msb-first bit%0d of %b", b, vt[v].word), 8'(if_a.ser_out), 8'(vt[v].seq_msb[c_W-1-b]));
                check($sformatf("lsb-first bit%0d of %b", b, vt[v].word), 8'(if_b.ser_out), 8'(vt[v].seq_lsb[c_W-1-b]));
                check($sformatf("ser_last bit%0d", b), 8'(if_a.ser_last), 8'(b == c_W - 1));
                step();
            end
            check("word_done after last bit", 8'(if_a.word_done), 8'd1);
            check("in_ready after last bit", 8'(if_a.in_ready), 8'd1);
            step();
        end
        repeat (3) step();

        // Backpressure while the second bit of 1100 is presented
        in_valid = 1'b1; in_data = 4'b1100; ser_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp bit0", 8'(if_a.ser_out), 8'd1);
        step();
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp hold value", 8'(if_a.ser_out), 8'd1);
            check("bp hold valid", 8'(if_a.ser_valid), 8'd1);
            step();
        end
        ser_ready = 1'b1;
        check("bp bit1", 8'(if_a.ser_out), 8'd1);
        step();
        check("bp bit2", 8'(if_a.ser_out), 8'd0);
        step();
        check("bp bit3", 8'(if_a.ser_out), 8'd0);
        check("bp bit3 last", 8'(if_a.ser_last), 8'd1);
        step();
        check("bp word_done", 8'(if_a.word_done), 8'd1);
        repeat (3) step();

        // in_valid held with changing data during a word
        in_valid = 1'b1; in_data = 4'b0110;
        step();
        for (int b = 0; b < c_W; b++) begin
            check("busy in_ready", 8'(if_a.in_ready), 8'd0);
            check($sformatf("busy word bit%0d", b), 8'(if_a.ser_out), 8'(b == 1 || b == 2));
            in_data = 4'($urandom);
            step();
        end
        check("next word accepted in idle", 8'(if_a.load_sel), 8'd1);
        step();
        in_valid = 1'b0;
        repeat (6) step();

        // Reset after the second bit discards the word
        in_valid = 1'b1; in_data = 4'b1100;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        #1;
        check("reset drops ser_valid", 8'(if_a.ser_valid), 8'd0);
        check("reset in_ready low", 8'(if_a.in_ready), 8'd0);
        check("reset ser_out low", 8'(if_a.ser_out), 8'd0);
        step();
        rst = 1'b0;
        repeat (3) begin
            check("no done after reset", 8'(if_a.word_done), 8'd0);
            step();
        end
        check("in_ready after reset release", 8'(if_a.in_ready), 8'd1);

        // Back-to-back words: accept period WIDTH+1 without gap, WIDTH+3 with two gap cycles
        in_valid = 1'b1; ser_ready = 1'b1;
        last_a = -1; last_c = -1; nacc_c = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (if_a.load_sel) begin
                if (last_a >= 0) check("accept period gap0", 8'(cyc - last_a), 8'(c_W + 1));
                last_a = cyc;
            end
            if (if_c.load_sel) begin
                if (last_c >= 0) check("accept period gap2", 8'(cyc - last_c), 8'(c_W + 3));
                last_c = cyc;
                nacc_c++;
            end
            in_data = 4'($urandom);
            step();
        end
        check("gap2 accepts seen", 8'(nacc_c >= 3), 8'd1);
        in_valid = 1'b0;
        repeat (6) step();

        // Random traffic, backpressure and occasional resets against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
